// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Shares one hex-to-7-segment decoder across N_DIGITS
//               common-anode digits by time-multiplexing. A blank slot comes
//               before each digit so the previous digit's segments never
//               appear on the next anode. The displayed value is held in a
//               shadow/active pair, so a whole frame always shows one value.
//
// Parameters  : N_DIGITS   number of digits scanned (>= 2)
//               DIV        clock cycles each digit stays lit (>= 2)
//
// Ports       : clock       in   system clock, rising edge
//               reset       in   synchronous, active-high reset
//               enable      in   1 = scanning, 0 = display dark
//               load        in   1-cycle strobe, captures value/blank_mask
//               value       in   nibble i = digit i (digit 0 = rightmost)
//               blank_mask  in   bit i = 1 forces digit i dark
//               hexa        out  nibble presented to the shared decoder
//               sseg_in     in   decoder result, active-low segments g..a
//               seg         out  registered segment drive, active-low
//               anode       out  digit enables, active-low, at most one low
//               frame_done  out  1-cycle pulse after the last digit of a frame
//
// Build option: LZ_SUPPRESS_EN -- when defined, leading-zero digits (i > 0
//               with nibble i and every higher nibble zero) are also blanked.
//
// Revision    : 1.0  initial release
// ============================================================================
module display_scan_ctrl #(
   parameter int N_DIGITS = 4,
   parameter int DIV      = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   blank_mask,
   output logic [3:0]            hexa,
   input  logic [6:0]            sseg_in,
   output logic [6:0]            seg,
   output logic [N_DIGITS-1:0]   anode,
   output logic                  frame_done
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [IDX_W-1:0]    c_last_idx  = IDX_W'(N_DIGITS - 1);
   localparam logic [TICK_W-1:0]   c_last_tick = TICK_W'(DIV - 1);
   localparam logic [6:0]          c_dark_seg  = 7'h7F;
   localparam logic [N_DIGITS-1:0] c_all_off   = {N_DIGITS{1'b1}};
   localparam logic [N_DIGITS-1:0] c_one       = N_DIGITS'(1);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t                  state_q,       state_d;
   logic [IDX_W-1:0]        idx_q,         idx_d;
   logic [TICK_W-1:0]       tick_q,        tick_d;
   logic [6:0]              seg_q,         seg_d;
   logic [N_DIGITS-1:0]     anode_q,       anode_d;
   logic                    frame_done_q,  frame_done_d;
   logic [4*N_DIGITS-1:0]   shadow_val_q,  shadow_val_d;
   logic [N_DIGITS-1:0]     shadow_mask_q, shadow_mask_d;
   logic [4*N_DIGITS-1:0]   active_val_q,  active_val_d;
   logic [N_DIGITS-1:0]     active_mask_q, active_mask_d;
   logic                    pending_q,     pending_d;

   // ------------------------------------------------------------------------
   // Digit selection from the active buffer
   // ------------------------------------------------------------------------
   logic [3:0]          cur_nibble;
   logic                cur_blank;
   logic [N_DIGITS-1:0] lz_blank;

`ifdef LZ_SUPPRESS_EN
   // Digit i is a leading zero when nibble i and all nibbles above it are 0.
   // Digit 0 is exempt so an all-zero value still shows a single "0".
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz_digit
         if (gi == 0) begin : g_lz_units
            assign lz_blank[gi] = 1'b0;
         end else begin : g_lz_upper
            assign lz_blank[gi] = ~|active_val_q[4*N_DIGITS-1:4*gi];
         end
      end
   endgenerate
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      cur_nibble = 4'h0;
      cur_blank  = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nibble = active_val_q[4*i +: 4];
            cur_blank  = active_mask_q[i] | lz_blank[i];
         end
      end
   end

   // The decoder input is only meaningful while scanning; it is parked at 0
   // when idle so the shared decoder sees a stable, known code.
   assign hexa = (state_q == ST_IDLE) ? 4'h0 : cur_nibble;

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      tick_d        = tick_q;
      seg_d         = seg_q;
      anode_d       = anode_q;
      frame_done_d  = 1'b0;
      shadow_val_d  = shadow_val_q;
      shadow_mask_d = shadow_mask_q;
      active_val_d  = active_val_q;
      active_mask_d = active_mask_q;
      pending_d     = pending_q;

      // Capture into the shadow buffer regardless of scan state; the active
      // buffer only follows at a frame boundary.
      if (load) begin
         shadow_val_d  = value;
         shadow_mask_d = blank_mask;
         pending_d     = 1'b1;
      end

      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         tick_d  = '0;
         seg_d   = c_dark_seg;
         anode_d = c_all_off;
      end else begin
         case (state_q)
            ST_IDLE: begin
               idx_d   = '0;
               tick_d  = '0;
               seg_d   = c_dark_seg;
               anode_d = c_all_off;
               state_d = ST_SETUP;
            end

            ST_SETUP: begin
               // Decoder output has settled during this cycle; latch it and
               // light exactly one anode.
               seg_d   = cur_blank ? c_dark_seg : sseg_in;
               anode_d = ~(c_one << idx_q);
               tick_d  = '0;
               state_d = ST_SHOW;
            end

            ST_SHOW: begin
               if (tick_q == c_last_tick) begin
                  // Anti-ghosting gap: everything dark for the SETUP slot.
                  anode_d = c_all_off;
                  seg_d   = c_dark_seg;
                  tick_d  = '0;
                  state_d = ST_SETUP;
                  if (idx_q == c_last_idx) begin
                     idx_d        = '0;
                     frame_done_d = 1'b1;
                     // Frame boundary: a same-edge load bypasses the shadow
                     // so it is shown from the very next frame.
                     if (load) begin
                        active_val_d  = value;
                        active_mask_d = blank_mask;
                        pending_d     = 1'b0;
                     end else if (pending_q) begin
                        active_val_d  = shadow_val_q;
                        active_mask_d = shadow_mask_q;
                        pending_d     = 1'b0;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               tick_d  = '0;
               seg_d   = c_dark_seg;
               anode_d = c_all_off;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         tick_q        <= '0;
         seg_q         <= c_dark_seg;
         anode_q       <= c_all_off;
         frame_done_q  <= 1'b0;
         shadow_val_q  <= '0;
         shadow_mask_q <= '0;
         active_val_q  <= '0;
         active_mask_q <= '0;
         pending_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         tick_q        <= tick_d;
         seg_q         <= seg_d;
         anode_q       <= anode_d;
         frame_done_q  <= frame_done_d;
         shadow_val_q  <= shadow_val_d;
         shadow_mask_q <= shadow_mask_d;
         active_val_q  <= active_val_d;
         active_mask_q <= active_mask_d;
         pending_q     <= pending_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign seg        = seg_q;
   assign anode      = anode_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl (N_DIGITS=4, DIV=4)
//               with a real hex-to-7-segment decoder on hexa -> sseg_in.
//               Expected outputs come from a frame-position model: the scan
//               position is a single counter inside a frame of
//               N_DIGITS*(1+DIV) cycles, and digit/slot follow by division.
// Revision    : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

   localparam int N      = 4;
   localparam int DIV    = 4;
   localparam int SLOT   = DIV + 1;
   localparam int PERIOD = N * SLOT;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  blank_mask = '0;
   logic [3:0]  hexa;
   logic [6:0]  sseg_in;
   logic [6:0]  seg;
   logic [3:0]  anode;
   logic        frame_done;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   bit          m_run;
   int          m_cnt;
   logic [15:0] m_act_v, m_sh_v;
   logic [3:0]  m_act_m, m_sh_m;
   bit          m_pend;
   bit          m_fd;

   display_scan_ctrl #(.N_DIGITS(N), .DIV(DIV)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .blank_mask (blank_mask),
      .hexa       (hexa),
      .sseg_in    (sseg_in),
      .seg        (seg),
      .anode      (anode),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb sseg_in = hex7(hexa);

   function automatic bit m_blanked(input int d);
      logic [15:0] upper;
      upper = m_act_v >> (4 * d);
      if (m_act_m[d]) return 1'b1;
`ifdef LZ_SUPPRESS_EN
      if (d > 0 && upper == 16'h0) return 1'b1;
`endif
      return (upper == 16'hFFFF) && 1'b0;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one clock edge with the inputs sampled there.
   task automatic model_edge(input bit r, e, l, input logic [15:0] v, input logic [3:0] m);
      bit frame_end;
      frame_end = 1'b0;
      m_fd      = 1'b0;
      if (r) begin
         m_run = 0; m_cnt = 0; m_pend = 0;
         m_act_v = '0; m_act_m = '0; m_sh_v = '0; m_sh_m = '0;
      end else begin
         if (e && m_run) begin
            m_cnt     = (m_cnt + 1) % PERIOD;
            frame_end = (m_cnt == 0);
         end else begin
            m_run = e;
            m_cnt = 0;
         end
         if (frame_end) begin
            m_fd = 1'b1;
            if (l) begin
               m_act_v = v; m_act_m = m; m_sh_v = v; m_sh_m = m; m_pend = 0;
            end else if (m_pend) begin
               m_act_v = m_sh_v; m_act_m = m_sh_m; m_pend = 0;
            end
         end else if (l) begin
            m_sh_v = v; m_sh_m = m; m_pend = 1;
         end
      end
   endtask

   task automatic check_outputs();
      int d, s;
      logic [3:0] exp_anode;
      logic [3:0] exp_hexa;
      logic [6:0] exp_seg;
      d = m_cnt / SLOT;
      s = m_cnt % SLOT;
      if (!m_run) begin
         exp_anode = 4'hF;
         exp_hexa  = 4'h0;
      end else begin
         exp_hexa  = 4'((m_act_v >> (4 * d)) & 16'hF);
         exp_anode = (s == 0) ? 4'hF : 4'(~(4'b0001 << d));
      end
      check("anode", 16'(anode), 16'(exp_anode));
      check("frame_done", 16'(frame_done), 16'(m_fd));
      check("hexa", 16'(hexa), 16'(exp_hexa));
      // Segment content is only defined while a digit is lit or when idle.
      if (!m_run || s != 0) begin
         exp_seg = (!m_run || m_blanked(d)) ? 7'h7F : hex7(exp_hexa);
         check("seg", 16'(seg), 16'(exp_seg));
      end
   endtask

   task automatic step(input bit r, e, l, input logic [15:0] v, input logic [3:0] m);
      reset = r; enable = e; load = l; value = v; blank_mask = m;
      @(posedge clock);
      model_edge(r, e, l, v, m);
      #1;
      check_outputs();
   endtask

   // Scan with no load until the model reaches a given frame position.
   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (!(m_run && m_cnt == target) && guard < 4 * PERIOD) begin
         step(0, 1, 0, 16'($urandom), 4'($urandom));
         guard++;
      end
      if (guard >= 4 * PERIOD) begin
         n_fail++;
         $error("FAIL run_to: position %0d not reached", target);
      end
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 1, 0, 16'($urandom), 4'($urandom));
   endtask

   initial begin
      m_run = 0; m_cnt = 0; m_pend = 0; m_fd = 0;
      m_act_v = '0; m_act_m = '0; m_sh_v = '0; m_sh_m = '0;

      // Reset state
      step(1, 0, 0, 16'h0, 4'h0);
      step(1, 1, 1, 16'hBEEF, 4'h5);

      // Enable with a simultaneous load of 12AF; first frame shows 0000,
      // following frames show 12AF.
      step(0, 1, 1, 16'h12AF, 4'h0);
      run(2 * PERIOD + 3);

      // Load mid-frame while digit 1 is lit.
      run_to(7);
      step(0, 1, 1, 16'h3333, 4'h0);
      run(2 * PERIOD);

      // Masked most-significant digit, value 0007.
      step(0, 1, 1, 16'h0007, 4'b1000);
      run(2 * PERIOD + 2);

      // Disable during SHOW of digit 2, then re-enable.
      run_to(12);
      step(0, 0, 0, 16'h0, 4'h0);
      step(0, 0, 0, 16'h0, 4'h0);
      run(PERIOD + 4);

      // Reset mid-SHOW.
      run_to(8);
      step(1, 1, 0, 16'h0, 4'h0);
      step(0, 1, 1, 16'h0C0D, 4'h0);
      run(PERIOD + 2);

      // Load on the frame_done-producing edge.
      run_to(PERIOD - 1);
      step(0, 1, 1, 16'h9E84, 4'h0);
      run(PERIOD + 2);

      // Value 0000: with leading-zero suppression only digit 0 shows.
      step(0, 1, 1, 16'h0000, 4'h0);
      run(2 * PERIOD);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         bit r, e, l;
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 15) != 0);
         l = ($urandom_range(0, 11) == 0);
         step(r, e, l, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
